alu_pipe_core: RTL and testbench

ALU_PIPE_CORE -- requirements
Module: alu_pipe_core

---
 rtl/alu_pipe_core_if.sv | 32 +++
 rtl/alu_pipe_core.sv | 210 +++++++++++++++++++++
 tb/tb_alu_pipe_core.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_core_if.sv
// alu_pipe_core_if
//    Handshake and data bundle between an instruction source / result
//    consumer (master) and alu_pipe_core (slave).
//    Instruction side : ACT, ALU_RDY, OP[3:0], MOVI[1:0], REG_A, REG_B, IMM, MEM
//    Result side      : EX_ALU, EX_ALU_VLD, EX_ALU_RDY, FIFO_CNT
interface alu_pipe_core_if #(
   parameter int pDataWidth = 8,
   parameter int pFifoDepth = 4
);
   logic                          ACT;
   logic                          ALU_RDY;
   logic [3:0]                    OP;
   logic [1:0]                    MOVI;
   logic [pDataWidth-1:0]         REG_A;
   logic [pDataWidth-1:0]         REG_B;
   logic [pDataWidth-1:0]         IMM;
   logic [pDataWidth-1:0]         MEM;
   logic [pDataWidth-1:0]         EX_ALU;
   logic                          EX_ALU_VLD;
   logic                          EX_ALU_RDY;
   logic [$clog2(pFifoDepth):0]   FIFO_CNT;

   modport master (
      output ACT, OP, MOVI, REG_A, REG_B, IMM, MEM, EX_ALU_RDY,
      input  ALU_RDY, EX_ALU, EX_ALU_VLD, FIFO_CNT
   );

   modport slave (
      input  ACT, OP, MOVI, REG_A, REG_B, IMM, MEM, EX_ALU_RDY,
      output ALU_RDY, EX_ALU, EX_ALU_VLD, FIFO_CNT
   );
endinterface

// File: rtl/alu_pipe_core.sv
// alu_pipe_core
//    Single-issue ALU with a shift-add multiplier and a result FIFO.
//    Ports:
//       CLK   - sole clock, rising edge
//       RESET - asynchronous, active-high
//       bus   - alu_pipe_core_if.slave (instruction accept + result FIFO head)
//    Single-cycle ops push their result at the accepting edge. MUL (OP=2)
//    runs pDataWidth shift-add steps, then waits in MUL_WR for FIFO space.
//    All outputs come from registers.
module alu_pipe_core #(
   parameter int pDataWidth = 8,
   parameter int pFifoDepth = 4
) (
   input  logic            CLK,
   input  logic            RESET,
   alu_pipe_core_if.slave  bus
);
   localparam int W  = pDataWidth;
   localparam int PW = $clog2(pFifoDepth);
   localparam int CW = $clog2(pDataWidth);
   localparam logic [W-1:0]  ZERO_C     = {W{1'b0}};
   localparam logic [W-1:0]  ONE_C      = W'(1);
   localparam logic [PW:0]   CNT_ZERO_C = {(PW+1){1'b0}};
   localparam logic [PW:0]   DEPTH_C    = (PW+1)'(pFifoDepth);
   localparam logic [CW-1:0] MUL_LAST_C = CW'(pDataWidth - 1);
   localparam logic [3:0]    OP_MUL_C   = 4'h2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MUL    = 2'd1,
      ST_MUL_WR = 2'd2
   } state_t;

   state_t          state_r, state_s;
   logic            rdy_r, vld_r;
   logic [W-1:0]    ex_alu_r;
   logic [W-1:0]    fifo_mem_r [0:pFifoDepth-1];
   logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
   logic [PW:0]     cnt_r;
   logic [W-1:0]    mul_a_r, mul_b_r, mul_acc_r;
   logic [CW-1:0]   mul_cnt_r;

   logic            accept_s, pop_s, push_s, mul_start_s, mul_step_s, rdy_s;
   logic [W-1:0]    op_b_s, push_data_s, head_s;
   logic [PW:0]     cnt_nxt_s, remain_s;
   logic [PW-1:0]   rd_ptr_nxt_s;

   // Single-cycle operation results; MUL is produced by the multiplier instead.
   function automatic logic [W-1:0] alu_f(input logic [3:0] op,
                                          input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] r;
      case (op)
         4'h0:    r = a + b;
         4'h1:    r = a - b;
         4'h3:    r = {a[W-2:0], 1'b0};
         4'h4:    r = {1'b0, a[W-1:1]};
         4'h5:    r = {a[W-2:0], a[W-1]};
         4'h6:    r = {a[0], a[W-1:1]};
         4'h7:    r = ~a;
         4'h8:    r = a & b;
         4'h9:    r = a | b;
         4'hA:    r = a ^ b;
         4'hB:    r = ~(a & b);
         4'hC:    r = ~(a | b);
         4'hD:    r = ~(a ^ b);
         4'hE:    r = a + ONE_C;
         4'hF:    r = a - ONE_C;
         default: r = ZERO_C;
      endcase
      return r;
   endfunction

   // Next-state, FIFO push/pop and next output values.
   always_comb begin
      state_s     = state_r;
      push_s      = 1'b0;
      push_data_s = ZERO_C;
      mul_start_s = 1'b0;
      mul_step_s  = 1'b0;

      case (bus.MOVI)
         2'b01:   op_b_s = bus.IMM;
         2'b10:   op_b_s = bus.MEM;
         default: op_b_s = bus.REG_B;
      endcase

      // rdy_r already implies IDLE and not full.
      accept_s = bus.ACT & rdy_r;
      pop_s    = vld_r & bus.EX_ALU_RDY;

      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (bus.OP == OP_MUL_C) begin
                  mul_start_s = 1'b1;
                  state_s     = ST_MUL;
               end else begin
                  push_s      = 1'b1;
                  push_data_s = alu_f(bus.OP, bus.REG_A, op_b_s);
                  state_s     = ST_IDLE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            mul_step_s = 1'b1;
            if (mul_cnt_r == MUL_LAST_C) begin
               state_s = ST_MUL_WR;
            end else begin
               state_s = ST_MUL;
            end
         end
         ST_MUL_WR: begin
            // A pop in this cycle does not count as free space.
            if (cnt_r < DEPTH_C) begin
               push_s      = 1'b1;
               push_data_s = mul_acc_r;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_MUL_WR;
            end
         end
         default: state_s = ST_IDLE;
      endcase

      cnt_nxt_s    = cnt_r + {{PW{1'b0}}, push_s} - {{PW{1'b0}}, pop_s};
      remain_s     = cnt_r - {{PW{1'b0}}, pop_s};
      rd_ptr_nxt_s = rd_ptr_r + PW'(pop_s);

      // Head after this edge: the word being written when it lands in an
      // otherwise empty FIFO, else the stored entry; empty keeps the old head.
      if (cnt_nxt_s == CNT_ZERO_C) begin
         head_s = ex_alu_r;
      end else if (remain_s == CNT_ZERO_C) begin
         head_s = push_data_s;
      end else begin
         head_s = fifo_mem_r[rd_ptr_nxt_s];
      end

      rdy_s = (state_s == ST_IDLE) && (cnt_nxt_s < DEPTH_C);
   end

   // FSM state register.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Result FIFO storage, pointers and occupancy.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < pFifoDepth; i++) begin
            fifo_mem_r[i] <= ZERO_C;
         end
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         cnt_r    <= CNT_ZERO_C;
      end else begin
         if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= push_data_s;
            wr_ptr_r             <= wr_ptr_r + PW'(1);
         end
         rd_ptr_r <= rd_ptr_nxt_s;
         cnt_r    <= cnt_nxt_s;
      end
   end

   // Registered outputs: ready, valid and FIFO head.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         rdy_r    <= 1'b0;
         vld_r    <= 1'b0;
         ex_alu_r <= ZERO_C;
      end else begin
         rdy_r    <= rdy_s;
         vld_r    <= (cnt_nxt_s != CNT_ZERO_C);
         ex_alu_r <= head_s;
      end
   end

   // Shift-add multiplier: one multiplier bit (LSB first) per MUL cycle.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mul_a_r   <= ZERO_C;
         mul_b_r   <= ZERO_C;
         mul_acc_r <= ZERO_C;
         mul_cnt_r <= {CW{1'b0}};
      end else if (mul_start_s) begin
         mul_a_r   <= bus.REG_A;
         mul_b_r   <= op_b_s;
         mul_acc_r <= ZERO_C;
         mul_cnt_r <= {CW{1'b0}};
      end else if (mul_step_s) begin
         mul_acc_r <= mul_acc_r + (mul_b_r[0] ? mul_a_r : ZERO_C);
         mul_a_r   <= {mul_a_r[W-2:0], 1'b0};
         mul_b_r   <= {1'b0, mul_b_r[W-1:1]};
         mul_cnt_r <= mul_cnt_r + CW'(1);
      end
   end

   assign bus.ALU_RDY    = rdy_r;
   assign bus.EX_ALU_VLD = vld_r;
   assign bus.EX_ALU     = ex_alu_r;
   assign bus.FIFO_CNT   = cnt_r;
endmodule

// File: tb/tb_alu_pipe_core.sv
// Directed and randomised checks for alu_pipe_core (pDataWidth=8, pFifoDepth=4).
module tb_alu_pipe_core;
   logic clk;
   logic rst;
   int   checks;
   int   failures;
   logic [7:0] q[$];

   alu_pipe_core_if #(.pDataWidth(8), .pFifoDepth(4)) bus_if ();

   alu_pipe_core #(.pDataWidth(8), .pFifoDepth(4)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] op, input logic [1:0] movi, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] imm, input logic [7:0] mem);
      bus_if.ACT   = 1'b1;
      bus_if.OP    = op;
      bus_if.MOVI  = movi;
      bus_if.REG_A = a;
      bus_if.REG_B = b;
      bus_if.IMM   = imm;
      bus_if.MEM   = mem;
   endtask

   function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [1:0] movi,
                                          input logic [7:0] a, input logic [7:0] rb,
                                          input logic [7:0] imm, input logic [7:0] mem);
      logic [7:0]  b;
      logic [15:0] p;
      b = (movi == 2'b01) ? imm : (movi == 2'b10) ? mem : rb;
      p = 16'(a) * 16'(b);
      case (op)
         4'h0: return 8'(a + b);
         4'h1: return 8'(a + ~b + 8'd1);
         4'h2: return p[7:0];
         4'h3: return 8'(a * 8'd2);
         4'h4: return a / 8'd2;
         4'h5: return (a << 1) | (a >> 7);
         4'h6: return (a >> 1) | (a << 7);
         4'h7: return 8'hFF ^ a;
         4'h8: return a & b;
         4'h9: return a | b;
         4'hA: return a ^ b;
         4'hB: return 8'hFF ^ (a & b);
         4'hC: return 8'hFF ^ (a | b);
         4'hD: return 8'hFF ^ (a ^ b);
         4'hE: return 8'(a + 8'd1);
         default: return 8'(a - 8'd1);
      endcase
   endfunction

   task automatic rand_cycle(input bit drive_act);
      bus_if.ACT        = drive_act ? ($urandom_range(0, 9) < 7) : 1'b0;
      bus_if.OP         = 4'($urandom_range(0, 15));
      bus_if.MOVI       = 2'($urandom_range(0, 3));
      bus_if.REG_A      = 8'($urandom);
      bus_if.REG_B      = 8'($urandom);
      bus_if.IMM        = 8'($urandom);
      bus_if.MEM        = 8'($urandom);
      bus_if.EX_ALU_RDY = drive_act ? ($urandom_range(0, 3) != 0) : 1'b1;
      #1;
      if (bus_if.EX_ALU_VLD && bus_if.EX_ALU_RDY) begin
         if (q.size() == 0) begin
            check_val("rand_unexpected_result", 32'(bus_if.EX_ALU), 32'hFFFF_FFFF);
         end else begin
            check_val("rand_result", 32'(bus_if.EX_ALU), 32'(q.pop_front()));
         end
      end
      if (bus_if.ACT && bus_if.ALU_RDY) begin
         q.push_back(ref_alu(bus_if.OP, bus_if.MOVI, bus_if.REG_A, bus_if.REG_B,
                             bus_if.IMM, bus_if.MEM));
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int bad;
      logic [7:0] exp_v [4];
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus_if.ACT = 1'b0; bus_if.OP = 4'h0; bus_if.MOVI = 2'b00;
      bus_if.REG_A = 8'h00; bus_if.REG_B = 8'h00; bus_if.IMM = 8'h00; bus_if.MEM = 8'h00;
      bus_if.EX_ALU_RDY = 1'b1;
      tick(); tick();

      // Reset state
      check_val("rst_alu_rdy", 32'(bus_if.ALU_RDY), 32'd0);
      check_val("rst_vld", 32'(bus_if.EX_ALU_VLD), 32'd0);
      check_val("rst_cnt", 32'(bus_if.FIFO_CNT), 32'd0);
      check_val("rst_ex_alu", 32'(bus_if.EX_ALU), 32'd0);
      rst = 1'b0;
      tick();
      check_val("rdy_after_rst", 32'(bus_if.ALU_RDY), 32'd1);

      // ADD with immediate, latency 1
      issue(4'h0, 2'b01, 8'hF0, 8'h00, 8'h20, 8'h00);
      tick();
      bus_if.ACT = 1'b0;
      check_val("add_vld", 32'(bus_if.EX_ALU_VLD), 32'd1);
      check_val("add_res", 32'(bus_if.EX_ALU), 32'h10);
      tick();
      check_val("add_popped_vld", 32'(bus_if.EX_ALU_VLD), 32'd0);
      check_val("add_popped_cnt", 32'(bus_if.FIFO_CNT), 32'd0);

      // MUL with memory operand; ACT held during MUL must be ignored
      issue(4'h2, 2'b10, 8'h0F, 8'h00, 8'h00, 8'h11);
      tick();
      issue(4'hE, 2'b00, 8'h33, 8'h00, 8'h00, 8'h00);
      bad = 0;
      for (int k = 1; k <= 9; k++) begin
         if (bus_if.ALU_RDY !== 1'b0 || bus_if.EX_ALU_VLD !== 1'b0) bad++;
         tick();
      end
      bus_if.ACT = 1'b0;
      check_val("mul_busy_cycles_bad", 32'(bad), 32'd0);
      check_val("mul_vld", 32'(bus_if.EX_ALU_VLD), 32'd1);
      check_val("mul_res", 32'(bus_if.EX_ALU), 32'hFF);
      check_val("mul_cnt_only_product", 32'(bus_if.FIFO_CNT), 32'd1);
      check_val("mul_rdy_back", 32'(bus_if.ALU_RDY), 32'd1);
      tick();
      check_val("mul_popped", 32'(bus_if.EX_ALU_VLD), 32'd0);

      // Fill FIFO, fifth accept ignored, drain in order
      bus_if.EX_ALU_RDY = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         issue(4'hE, 2'b00, 8'(i), 8'h00, 8'h00, 8'h00);
         tick();
      end
      bus_if.ACT = 1'b0;
      check_val("full_rdy", 32'(bus_if.ALU_RDY), 32'd0);
      check_val("full_cnt", 32'(bus_if.FIFO_CNT), 32'd4);
      bus_if.EX_ALU_RDY = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         check_val("drain_vld", 32'(bus_if.EX_ALU_VLD), 32'd1);
         check_val("drain_res", 32'(bus_if.EX_ALU), 32'(i));
         tick();
         if (i == 2) check_val("rdy_after_first_pop", 32'(bus_if.ALU_RDY), 32'd1);
      end
      check_val("drain_empty", 32'(bus_if.EX_ALU_VLD), 32'd0);
      check_val("drain_cnt", 32'(bus_if.FIFO_CNT), 32'd0);
      check_val("hold_last_head", 32'(bus_if.EX_ALU), 32'd5);

      // Three results queued, then MUL fills the last slot
      bus_if.EX_ALU_RDY = 1'b0;
      issue(4'h9, 2'b00, 8'h0C, 8'h30, 8'h00, 8'h00); tick();
      issue(4'h5, 2'b00, 8'h81, 8'h00, 8'h00, 8'h00); tick();
      issue(4'hD, 2'b01, 8'hF0, 8'h00, 8'hAA, 8'h00); tick();
      issue(4'h2, 2'b11, 8'h07, 8'h09, 8'h00, 8'h00); tick();
      bus_if.ACT = 1'b0;
      repeat (9) tick();
      check_val("mulfull_cnt", 32'(bus_if.FIFO_CNT), 32'd4);
      check_val("mulfull_rdy", 32'(bus_if.ALU_RDY), 32'd0);
      exp_v[0] = 8'h3C; exp_v[1] = 8'h03; exp_v[2] = 8'hA5; exp_v[3] = 8'h3F;
      bus_if.EX_ALU_RDY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_val("mulfull_vld", 32'(bus_if.EX_ALU_VLD), 32'd1);
         check_val("mulfull_res", 32'(bus_if.EX_ALU), 32'(exp_v[i]));
         tick();
      end
      check_val("mulfull_empty", 32'(bus_if.FIFO_CNT), 32'd0);

      // Asynchronous reset three cycles into MUL
      issue(4'h2, 2'b00, 8'h05, 8'h03, 8'h00, 8'h00);
      tick();
      bus_if.ACT = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      #1;
      check_val("midmul_rst_rdy", 32'(bus_if.ALU_RDY), 32'd0);
      check_val("midmul_rst_vld", 32'(bus_if.EX_ALU_VLD), 32'd0);
      check_val("midmul_rst_cnt", 32'(bus_if.FIFO_CNT), 32'd0);
      tick(); tick();
      rst = 1'b0;
      bad = 0;
      repeat (15) begin
         tick();
         if (bus_if.EX_ALU_VLD !== 1'b0 || bus_if.FIFO_CNT !== 3'd0) bad++;
      end
      check_val("midmul_no_result", 32'(bad), 32'd0);
      check_val("midmul_rdy_back", 32'(bus_if.ALU_RDY), 32'd1);

      // Random mix against reference model
      q.delete();
      repeat (400) rand_cycle(1'b1);
      for (int n = 0; n < 60 && (q.size() != 0 || bus_if.EX_ALU_VLD); n++) rand_cycle(1'b0);
      check_val("rand_model_empty", 32'(q.size()), 32'd0);
      check_val("rand_dut_empty", 32'(bus_if.EX_ALU_VLD), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
